// File: rtl/ethernet_mii_receive.sv
// MII receive path: oversamples the PHY receive pins on the system clock and turns
// nibbles into a byte stream with sof/eof markers, length and FCS/framing status.
module ethernet_mii_receive #(
    parameter int unsigned MAX_BYTES = 1522,
    parameter int unsigned MIN_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eth_rx_clk,
    input  logic        eth_rx_dv,
    input  logic        eth_rx_er,
    input  logic [3:0]  eth_rx_d,
    output logic [7:0]  data,
    output logic        valid,
    output logic        sof,
    output logic        eof,
    output logic        crc_ok,
    output logic        error,
    output logic [15:0] length
);

    localparam logic [15:0] MaxLen     = 16'(MAX_BYTES);
    localparam logic [15:0] MinLen     = 16'(MIN_BYTES);
    localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
    localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
    localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        StDrop,
        StIdle,
        StPreamble,
        StData
    } state_e;

    logic [1:0]  rx_clk_sync;
    logic [1:0]  dv_sync;
    logic [1:0]  er_sync;
    logic [3:0]  d_meta;
    logic [3:0]  d_sync;
    logic        rx_clk_prev;
    logic        sample;

    state_e      state;
    logic [31:0] crc;
    logic [15:0] count;
    logic        phase;
    logic [3:0]  low_nib;
    logic        err_sticky;
    logic        sof_pend;
    logic [7:0]  rx_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_clk_sync <= 2'b00;
            dv_sync     <= 2'b00;
            er_sync     <= 2'b00;
            d_meta      <= 4'h0;
            d_sync      <= 4'h0;
            rx_clk_prev <= 1'b0;
        end else begin
            rx_clk_sync <= {rx_clk_sync[0], eth_rx_clk};
            dv_sync     <= {dv_sync[0], eth_rx_dv};
            er_sync     <= {er_sync[0], eth_rx_er};
            d_meta      <= eth_rx_d;
            d_sync      <= d_meta;
            rx_clk_prev <= rx_clk_sync[1];
        end
    end

    // One sample per PHY clock: the cycle the synchronised rx clock first reads high.
    assign sample  = rx_clk_sync[1] & ~rx_clk_prev;
    assign rx_byte = {d_sync, low_nib};

    function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] c;
        c = crc_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StDrop;
            crc        <= CrcInit;
            count      <= 16'h0;
            phase      <= 1'b0;
            low_nib    <= 4'h0;
            err_sticky <= 1'b0;
            sof_pend   <= 1'b0;
            data       <= 8'h0;
            valid      <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            crc_ok     <= 1'b0;
            error      <= 1'b0;
            length     <= 16'h0;
        end else begin
            data   <= 8'h0;
            valid  <= 1'b0;
            sof    <= 1'b0;
            eof    <= 1'b0;
            crc_ok <= 1'b0;
            error  <= 1'b0;
            length <= 16'h0;
            if (sample) begin
                unique case (state)
                    StDrop: begin
                        if (!dv_sync[1]) state <= StIdle;
                    end
                    StIdle: begin
                        if (dv_sync[1]) begin
                            state <= (d_sync == 4'h5) ? StPreamble : StDrop;
                        end
                    end
                    StPreamble: begin
                        if (!dv_sync[1]) begin
                            state <= StIdle;
                        end else if (d_sync == 4'hD) begin
                            state      <= StData;
                            phase      <= 1'b0;
                            count      <= 16'h0;
                            err_sticky <= 1'b0;
                            crc        <= CrcInit;
                            sof_pend   <= 1'b1;
                        end else if (d_sync != 4'h5) begin
                            state <= StDrop;
                        end
                    end
                    StData: begin
                        if (dv_sync[1]) begin
                            if (er_sync[1]) err_sticky <= 1'b1;
                            if (!phase) begin
                                low_nib <= d_sync;
                                phase   <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                crc   <= crc_next(crc, rx_byte);
                                if (count < MaxLen) begin
                                    count    <= count + 16'd1;
                                    data     <= rx_byte;
                                    valid    <= 1'b1;
                                    sof      <= sof_pend;
                                    sof_pend <= 1'b0;
                                end else begin
                                    // Oversize: stop emitting, pin count one past the limit.
                                    count      <= MaxLen + 16'd1;
                                    err_sticky <= 1'b1;
                                end
                            end
                        end else begin
                            state  <= StIdle;
                            eof    <= 1'b1;
                            length <= count;
                            crc_ok <= (crc == CrcResidue);
                            error  <= err_sticky | phase | (count < MinLen) | (count > MaxLen);
                        end
                    end
                    default: state <= StDrop;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ethernet_mii_receive.sv
// Bench for ethernet_mii_receive: drives MII frames at 25 MHz and compares the byte
// stream and eof status against a frame-level reference model.
module tb_ethernet_mii_receive;

    localparam int MaxBytes = 1522;
    localparam int MinBytes = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eth_rx_clk = 1'b0;
    logic        eth_rx_dv = 1'b0;
    logic        eth_rx_er = 1'b0;
    logic [3:0]  eth_rx_d = 4'h0;
    logic [7:0]  data;
    logic        valid;
    logic        sof;
    logic        eof;
    logic        crc_ok;
    logic        error;
    logic [15:0] length;

    always #5 clk = ~clk;

    ethernet_mii_receive #(
        .MAX_BYTES(MaxBytes),
        .MIN_BYTES(MinBytes)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .eth_rx_clk(eth_rx_clk),
        .eth_rx_dv (eth_rx_dv),
        .eth_rx_er (eth_rx_er),
        .eth_rx_d  (eth_rx_d),
        .data      (data),
        .valid     (valid),
        .sof       (sof),
        .eof       (eof),
        .crc_ok    (crc_ok),
        .error     (error),
        .length    (length)
    );

    int          n_checks = 0;
    int          n_fail = 0;

    // Output monitor (sole writer of these)
    logic [7:0]  rx_q[$];
    int          n_sof = 0;
    int          sof_idx = -1;
    int          n_eof = 0;
    int          n_overlap = 0;
    logic        last_crc_ok = 1'b0;
    logic        last_error = 1'b0;
    logic [15:0] last_len = 16'h0;

    always @(negedge clk) begin
        if (sof) begin
            n_sof++;
            sof_idx = valid ? rx_q.size() : -1;
        end
        if (valid) rx_q.push_back(data);
        if (eof) begin
            n_eof++;
            last_crc_ok = crc_ok;
            last_error  = error;
            last_len    = length;
            if (valid) n_overlap++;
        end
    end

    logic [7:0]  tx_q[$];
    int          rst_byte = -1;
    int          snap_valid = 0;
    int          snap_eof = 0;

    typedef struct {
        int nbytes;
        int flip_byte;
        int er_byte;
        bit extra;
        bit exp_crc;
        bit exp_err;
        int exp_len;
        int exp_nvalid;
    } vec_t;

    vec_t  vecs[5];
    string vec_name[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One PHY clock: pins change on the falling edge, rising edge 20 ns later.
    task automatic nibble(input logic dv, input logic er, input logic [3:0] d, input logic pulse);
        eth_rx_dv = dv;
        eth_rx_er = er;
        eth_rx_d  = d;
        #10;
        reset = pulse;
        #10;
        reset = 1'b0;
        eth_rx_clk = 1'b1;
        #20;
        eth_rx_clk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) nibble(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ tx_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n, input bit rnd, input int flip_byte);
        logic [31:0] f;
        tx_q.delete();
        for (int i = 0; i < n - 4; i++) tx_q.push_back(rnd ? 8'($urandom) : 8'(i));
        f = fcs_of(n - 4);
        for (int k = 0; k < 4; k++) tx_q.push_back(f[8*k +: 8]);
        if (flip_byte >= 0) tx_q[flip_byte][0] = ~tx_q[flip_byte][0];
    endtask

    task automatic send_frame(input int er_byte, input bit extra);
        for (int i = 0; i < 15; i++) nibble(1'b1, 1'b0, 4'h5, 1'b0);
        nibble(1'b1, 1'b0, 4'hD, 1'b0);
        for (int i = 0; i < tx_q.size(); i++) begin
            nibble(1'b1, 1'(i == er_byte), tx_q[i][3:0], 1'(i == rst_byte));
            if (i == rst_byte) begin
                snap_valid = rx_q.size();
                snap_eof   = n_eof;
            end
            nibble(1'b1, 1'b0, tx_q[i][7:4], 1'b0);
        end
        if (extra) nibble(1'b1, 1'b0, 4'h0, 1'b0);
        idle(3);
    endtask

    // Frame-level reference: counts, CRC verdict from the appended FCS, error causes.
    task automatic model(input int er_byte, input bit extra, output int nv, output bit c,
                         output bit e, output int len);
        int n;
        n   = tx_q.size();
        nv  = (n < MaxBytes) ? n : MaxBytes;
        len = (n > MaxBytes) ? MaxBytes + 1 : n;
        c   = (fcs_of(n - 4) == {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]});
        e   = (er_byte >= 0 && er_byte < n) || extra || (n < MinBytes) || (n > MaxBytes);
    endtask

    task automatic run_frame(input string tag, input int er_byte, input bit extra,
                             input int exp_nvalid, input bit exp_crc, input bit exp_err,
                             input int exp_len);
        int base_q, base_sof, base_eof, bad, got;
        base_q   = rx_q.size();
        base_sof = n_sof;
        base_eof = n_eof;
        send_frame(er_byte, extra);
        got = rx_q.size() - base_q;
        chk({tag, " valid_count"}, got, exp_nvalid);
        bad = -1;
        for (int i = 0; i < got && i < exp_nvalid; i++) begin
            if (bad < 0 && rx_q[base_q + i] !== tx_q[i]) bad = i;
        end
        chk({tag, " first_bad_byte_idx"}, bad, -1);
        chk({tag, " sof_count"}, n_sof - base_sof, 1);
        chk({tag, " sof_position"}, sof_idx, base_q);
        chk({tag, " eof_count"}, n_eof - base_eof, 1);
        chk({tag, " crc_ok"}, 32'(last_crc_ok), 32'(exp_crc));
        chk({tag, " error"}, 32'(last_error), 32'(exp_err));
        chk({tag, " length"}, 32'(last_len), exp_len);
    endtask

    initial begin
        int nv, len, n, er_b, flip;
        bit c, e, ex;
        int base_q, base_eof;

        vecs[0] = '{64, -1, -1, 1'b0, 1'b1, 1'b0, 64, 64};  vec_name[0] = "good";
        vecs[1] = '{64, 10, -1, 1'b0, 1'b0, 1'b0, 64, 64};  vec_name[1] = "bitflip";
        vecs[2] = '{64, -1, 20, 1'b0, 1'b1, 1'b1, 64, 64};  vec_name[2] = "phy_er";
        vecs[3] = '{40, -1, -1, 1'b0, 1'b1, 1'b1, 40, 40};  vec_name[3] = "runt";
        vecs[4] = '{64, -1, -1, 1'b1, 1'b1, 1'b1, 64, 64};  vec_name[4] = "odd_nibble";

        #40;
        chk("reset valid", 32'(valid), 0);
        chk("reset sof", 32'(sof), 0);
        chk("reset eof", 32'(eof), 0);
        chk("reset data", 32'(data), 0);
        chk("reset status", {crc_ok, error, length}, 0);
        #2;
        reset = 1'b0;
        idle(4);

        for (int v = 0; v < 5; v++) begin
            build_frame(vecs[v].nbytes, 1'b0, vecs[v].flip_byte);
            run_frame(vec_name[v], vecs[v].er_byte, vecs[v].extra, vecs[v].exp_nvalid,
                      vecs[v].exp_crc, vecs[v].exp_err, vecs[v].exp_len);
        end

        // Broken preamble: everything up to the next dv=0 must be ignored.
        base_q   = rx_q.size();
        base_eof = n_eof;
        for (int i = 0; i < 3; i++) nibble(1'b1, 1'b0, 4'h5, 1'b0);
        nibble(1'b1, 1'b0, 4'h3, 1'b0);
        nibble(1'b1, 1'b0, 4'h5, 1'b0);
        nibble(1'b1, 1'b0, 4'hD, 1'b0);
        for (int i = 0; i < 40; i++) nibble(1'b1, 1'b0, 4'(i), 1'b0);
        idle(3);
        chk("bad_preamble valid_count", rx_q.size() - base_q, 0);
        chk("bad_preamble eof_count", n_eof - base_eof, 0);
        build_frame(64, 1'b0, -1);
        run_frame("after_bad_preamble", -1, 1'b0, 64, 1'b1, 1'b0, 64);

        // Reset during byte 30 with dv still high.
        build_frame(64, 1'b0, -1);
        rst_byte = 30;
        send_frame(-1, 1'b0);
        rst_byte = -1;
        chk("midreset valid_after_reset", rx_q.size() - snap_valid, 0);
        chk("midreset eof_after_reset", n_eof - snap_eof, 0);
        build_frame(64, 1'b1, -1);
        run_frame("after_reset", -1, 1'b0, 64, 1'b1, 1'b0, 64);

        build_frame(1600, 1'b0, -1);
        run_frame("oversize", -1, 1'b0, 1522, 1'b1, 1'b1, 1523);

        for (int r = 0; r < 6; r++) begin
            n    = $urandom_range(30, 100);
            flip = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            er_b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            ex   = ($urandom_range(0, 3) == 0);
            build_frame(n, 1'b1, flip);
            model(er_b, ex, nv, c, e, len);
            run_frame($sformatf("random%0d_n%0d", r, n), er_b, ex, nv, c, e, len);
        end

        chk("valid_eof_same_cycle", n_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
